// File: rtl/apb_arbiter_2m.sv
// apb_arbiter_2m: shares one APB completer bus between two APB requesters.
//
// Round-robin arbitration, one transfer at a time. Every completer-side output and every
// requester-side response is driven from flops. Completer inputs never reach a requester
// combinationally. A requester stays in its ACCESS phase until its m_pready pulse arrives.
// An optional watchdog ends a completer transfer that never completes.
//
// Ports (requester i uses slice [i*W +: W] of each packed m_* vector):
//   S_AXI_ACLK, S_AXI_ARESET         clock, asynchronous active-high reset
//   m_paddr/pprot/psel/penable/
//   m_pwrite/pwdata/pstrb            requester request side (2 requesters)
//   m_pready/prdata/pslverr          requester response side
//   paddr/pprot/psel/penable/
//   pwrite/pwdata/pstrb              completer request side
//   pready/prdata/pslverr            completer response side
//   grant                            one-hot bus owner, 0 when idle
//   timeout_err                      1-cycle pulse when the watchdog ends a transfer
module apb_arbiter_2m #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESET,
    input  logic [2*ADDR_WIDTH-1:0]     m_paddr,
    input  logic [5:0]                  m_pprot,
    input  logic [1:0]                  m_psel,
    input  logic [1:0]                  m_penable,
    input  logic [1:0]                  m_pwrite,
    input  logic [2*DATA_WIDTH-1:0]     m_pwdata,
    input  logic [2*DATA_WIDTH/8-1:0]   m_pstrb,
    output logic [1:0]                  m_pready,
    output logic [2*DATA_WIDTH-1:0]     m_prdata,
    output logic [1:0]                  m_pslverr,
    output logic [ADDR_WIDTH-1:0]       paddr,
    output logic [2:0]                  pprot,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [DATA_WIDTH-1:0]       pwdata,
    output logic [DATA_WIDTH/8-1:0]     pstrb,
    input  logic                        pready,
    input  logic [DATA_WIDTH-1:0]       prdata,
    input  logic                        pslverr,
    output logic [1:0]                  grant,
    output logic                        timeout_err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [1:0]              grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    sel;

    // A requester's ACCESS phase is implied by it holding psel; penable carries no extra info.
    logic unused_penable;
    assign unused_penable = ^m_penable;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = '0;
        rsp_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        // Both requesting: the one that did not win last time goes first.
        sel = (m_psel == 2'b11) ? ~last_grant_q : m_psel[1];

        unique case (state_q)
            StIdle: begin
                if (|m_psel) begin
                    paddr_d      = sel ? m_paddr[ADDR_WIDTH +: ADDR_WIDTH] : m_paddr[ADDR_WIDTH-1:0];
                    pprot_d      = sel ? m_pprot[5:3] : m_pprot[2:0];
                    pwrite_d     = sel ? m_pwrite[1] : m_pwrite[0];
                    pwdata_d     = sel ? m_pwdata[DATA_WIDTH +: DATA_WIDTH]
                                       : m_pwdata[DATA_WIDTH-1:0];
                    pstrb_d      = sel ? m_pstrb[STRB_WIDTH +: STRB_WIDTH]
                                       : m_pstrb[STRB_WIDTH-1:0];
                    grant_d      = sel ? 2'b10 : 2'b01;
                    last_grant_d = sel;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    cnt_d        = '0;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    state_d     = StResp;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            grant_q       <= 2'b00;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign paddr       = paddr_q;
    assign pprot       = pprot_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

    // Response flops are nonzero only in RESP; grant steers them to the owner only.
    assign m_pready  = rsp_valid_q ? grant_q : 2'b00;
    assign m_pslverr = (rsp_valid_q && rsp_err_q) ? grant_q : 2'b00;
    assign m_prdata  = {({DATA_WIDTH{grant_q[1]}} & rsp_data_q),
                        ({DATA_WIDTH{grant_q[0]}} & rsp_data_q)};

endmodule
